// File: rtl/vga_pkg.sv
// Shared definitions for the sprite compositor: default screen geometry,
// overlap-mode encoding, the sprite palette and a saturating nibble add.
package vga_pkg;

  localparam int CORDW = 10;
  localparam int H_RES = 640;
  localparam int V_RES = 480;

  typedef enum logic [1:0] {
    MODE_PRIO = 2'd0,
    MODE_MAX  = 2'd1,
    MODE_INV  = 2'd2,
    MODE_ADD  = 2'd3
  } mode_e;

  // Entry i is the colour of sprite i (12-bit RGB, 4 bits per channel).
  localparam logic [11:0] PALETTE [8] = '{
    12'hF00, 12'hFFF, 12'h059, 12'h4A2,
    12'h84C, 12'h0C3, 12'hA60, 12'h36F
  };

  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4] ? 4'hF : s[3:0];
  endfunction

endpackage

// File: rtl/vga_sprite_motion.sv
// One bouncing square: position/direction registers, edge bounce and the
// per-pixel hit test.
// Ports: clk/rst (sync, active-high), step (advance one frame of motion),
// sx/sy (current pixel), hit (pixel lies inside this square).
module vga_sprite_motion #(
  parameter int   CORDW  = 10,
  parameter int   SIZE   = 32,
  parameter int   SPEED  = 1,
  parameter int   H_RES  = 640,
  parameter int   V_RES  = 480,
  parameter int   X0     = 0,
  parameter int   Y0     = 0,
  parameter logic DY_NEG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  output logic             hit
);
  import vga_pkg::*;

  // One extra bit so p+SPEED+SIZE and x+SIZE never wrap.
  localparam int W = CORDW + 1;

  logic [CORDW-1:0] x, y;
  logic             dx_neg, dy_neg;

  // Returns {new direction (1 = negative), new position} for one axis.
  function automatic logic [CORDW:0] bounce(input logic [CORDW-1:0] p,
                                            input logic neg, input int res);
    logic [W-1:0] pw;
    pw = {1'b0, p};
    if (!neg) begin
      if (pw + W'(SPEED) + W'(SIZE) > W'(res)) return {1'b1, CORDW'(res - SIZE)};
      return {1'b0, p + CORDW'(SPEED)};
    end
    if (pw < W'(SPEED)) return {1'b0, {CORDW{1'b0}}};
    return {1'b1, p - CORDW'(SPEED)};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      x      <= CORDW'(X0);
      y      <= CORDW'(Y0);
      dx_neg <= 1'b0;
      dy_neg <= DY_NEG;
    end else if (step) begin
      {dx_neg, x} <= bounce(x, dx_neg, H_RES);
      {dy_neg, y} <= bounce(y, dy_neg, V_RES);
    end
  end

  assign hit = ({1'b0, sx} >= {1'b0, x}) && ({1'b0, sx} < {1'b0, x} + W'(SIZE)) &&
               ({1'b0, sy} >= {1'b0, y}) && ({1'b0, sy} < {1'b0, y} + W'(SIZE));

endmodule

// File: rtl/vga_sprite_compositor.sv
// N-sprite bouncing-square compositor between vga_sync and the VGA pins.
// Squares move once per frame on the first blanking line; pixels are
// composited under a per-frame latched overlap mode.
// Ports: clk_pix/rst_pix (sync, active-high), sx/sy/de/hsync/vsync from
// vga_sync, mode/pause requests (latched at frame tick), registered VGA
// outputs delayed 2 cycles, frame_tick pulse.
module vga_sprite_compositor #(
  parameter int          N_SPR    = 4,
  parameter int          SIZE     = 32,
  parameter int          SPEED    = 1,
  parameter int          H_RES    = 640,
  parameter int          V_RES    = 480,
  parameter int          CORDW    = 10,
  parameter logic [11:0] BG_COLOR = 12'h137
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  input  logic [1:0]       mode,
  input  logic             pause,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b,
  output logic             frame_tick
);
  import vga_pkg::*;

  mode_e mode_q;
  logic  pause_q;
  logic  tick_pos;
  logic  step;

  assign tick_pos = (sx == '0) && (sy == CORDW'(V_RES));
  // Motion happens on the edge that ends the tick cycle, so the freshly
  // latched pause already applies to this frame's update.
  assign step = frame_tick & ~pause_q;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      frame_tick <= 1'b0;
      mode_q     <= MODE_PRIO;
      pause_q    <= 1'b0;
    end else begin
      frame_tick <= tick_pos;
      if (tick_pos) begin
        mode_q  <= mode_e'(mode);
        pause_q <= pause;
      end
    end
  end

  logic [N_SPR-1:0] hit, hit_q;

  for (genvar i = 0; i < N_SPR; i++) begin : g_spr
    vga_sprite_motion #(
      .CORDW (CORDW), .SIZE(SIZE), .SPEED(SPEED), .H_RES(H_RES), .V_RES(V_RES),
      .X0    (i * (H_RES / N_SPR)),
      .Y0    (i * (V_RES / N_SPR)),
      .DY_NEG(1'(i % 2))
    ) u_mot (
      .clk (clk_pix), .rst(rst_pix), .step(step),
      .sx  (sx), .sy(sy), .hit(hit[i])
    );
  end

  // Stage 1: hit vector with matching sync/enable.
  logic de_q, hs_q, vs_q;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      hit_q <= '0;
      de_q  <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      hit_q <= hit;
      de_q  <= de;
      hs_q  <= hsync;
      vs_q  <= vsync;
    end
  end

  // Composite from the stage-1 hit vector.
  logic [11:0] rgb, prio, c;
  logic [3:0]  mr, mg, mb, ar, ag, ab, cnt;

  always_comb begin
    rgb  = BG_COLOR;
    prio = BG_COLOR;
    c    = '0;
    {mr, mg, mb} = '0;
    {ar, ag, ab} = '0;
    cnt  = '0;
    // Walk high to low so the lowest-index hit is left in prio.
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (hit_q[i]) begin
        c    = PALETTE[i[2:0]];
        prio = c;
        cnt  = cnt + 4'd1;
        if (c[11:8] > mr) mr = c[11:8];
        if (c[7:4]  > mg) mg = c[7:4];
        if (c[3:0]  > mb) mb = c[3:0];
        ar = sat_add4(ar, c[11:8]);
        ag = sat_add4(ag, c[7:4]);
        ab = sat_add4(ab, c[3:0]);
      end
    end
    case (mode_q)
      MODE_PRIO: rgb = prio;
      MODE_MAX:  rgb = {mr, mg, mb};
      MODE_INV:  rgb = (cnt > 4'd1) ? 12'h000 : prio;
      default:   rgb = {ar, ag, ab};
    endcase
    if (hit_q == '0) rgb = BG_COLOR;
    if (!de_q)       rgb = 12'h000;
  end

  // Stage 2: pins.
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
      {vga_r, vga_g, vga_b} <= '0;
    end else begin
      vga_hsync <= hs_q;
      vga_vsync <= vs_q;
      {vga_r, vga_g, vga_b} <= rgb;
    end
  end

endmodule

// File: tb/tb_vga_sprite_compositor.sv
// Randomized bench for vga_sprite_compositor on a small screen so squares
// overlap and bounce often. A behavioural model tracks square positions
// and computes expected pixels; outputs are compared 2 cycles later.
module tb_vga_sprite_compositor;
  localparam int          N  = 4;
  localparam int          SZ = 32;
  localparam int          SP = 3;
  localparam int          HR = 128;
  localparam int          VR = 96;
  localparam int          CW = 10;
  localparam logic [11:0] BG = 12'h137;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] sx, sy;
  logic          de, hs, vs, pause;
  logic [1:0]    mode;
  logic          vhs, vvs, ft;
  logic [3:0]    r, g, b;

  always #5 clk = ~clk;

  vga_sprite_compositor #(
    .N_SPR(N), .SIZE(SZ), .SPEED(SP), .H_RES(HR), .V_RES(VR), .CORDW(CW), .BG_COLOR(BG)
  ) dut (
    .clk_pix(clk), .rst_pix(rst), .sx(sx), .sy(sy), .de(de), .hsync(hs), .vsync(vs),
    .mode(mode), .pause(pause), .vga_hsync(vhs), .vga_vsync(vvs),
    .vga_r(r), .vga_g(g), .vga_b(b), .frame_tick(ft)
  );

  int total = 0;
  int bad   = 0;

  logic [11:0] pal [8] = '{12'hF00, 12'hFFF, 12'h059, 12'h4A2,
                           12'h84C, 12'h0C3, 12'hA60, 12'h36F};

  int px [N];
  int py [N];
  bit xn [N];
  bit yn [N];
  int m_mode, n_mode;
  bit n_pause;

  typedef struct {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;
  exp_t q[$];

  task automatic mv(input int p, input bit n, input int res, output int po, output bit no);
    po = p; no = n;
    if (!n) begin
      if (p + SP + SZ > res) begin po = res - SZ; no = 1'b1; end
      else po = p + SP;
    end else begin
      if (p < SP) begin po = 0; no = 1'b0; end
      else po = p - SP;
    end
  endtask

  function automatic logic [11:0] pix(input int x, input int y);
    logic [11:0] hl[$];
    int sr, sg, sb, mr, mg, mb;
    for (int i = 0; i < N; i++)
      if (x >= px[i] && x < px[i] + SZ && y >= py[i] && y < py[i] + SZ) hl.push_back(pal[i]);
    if (hl.size() == 0) return BG;
    sr = 0; sg = 0; sb = 0; mr = 0; mg = 0; mb = 0;
    foreach (hl[k]) begin
      sr += int'(hl[k][11:8]); sg += int'(hl[k][7:4]); sb += int'(hl[k][3:0]);
      if (int'(hl[k][11:8]) > mr) mr = int'(hl[k][11:8]);
      if (int'(hl[k][7:4])  > mg) mg = int'(hl[k][7:4]);
      if (int'(hl[k][3:0])  > mb) mb = int'(hl[k][3:0]);
    end
    case (m_mode)
      0: return hl[0];
      1: return {4'(mr), 4'(mg), 4'(mb)};
      2: return (hl.size() == 1) ? hl[0] : 12'h000;
      default: return {4'(sr > 15 ? 15 : sr), 4'(sg > 15 ? 15 : sg), 4'(sb > 15 ? 15 : sb)};
    endcase
  endfunction

  task automatic cyc(input int x, input int y, input bit d, input bit h, input bit v);
    exp_t e;
    bit   tk;
    sx = CW'(x); sy = CW'(y); de = d; hs = h; vs = v;
    mode  = 2'($urandom);
    pause = 1'($urandom);
    tk = (x == 0 && y == VR);
    if (tk) begin n_mode = int'(mode); n_pause = pause; end
    e.hs = h; e.vs = v;
    e.rgb = d ? pix(x, y) : 12'h000;
    q.push_back(e);
    @(posedge clk); #1;
    total++;
    assert (ft === tk) else begin
      bad++; $error("FAIL frame_tick at (%0d,%0d): got %b want %b", x, y, ft, tk);
    end
    if (q.size() == 2) begin
      e = q.pop_front();
      total++;
      assert ({vhs, vvs, r, g, b} === {e.hs, e.vs, e.rgb}) else begin
        bad++;
        $error("FAIL pixel_out: got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h",
               vhs, vvs, {r, g, b}, e.hs, e.vs, e.rgb);
      end
    end
  endtask

  task automatic do_reset();
    exp_t e;
    rst = 1'b1;
    sx = CW'($urandom_range(0, HR - 1)); sy = CW'($urandom_range(0, VR - 1));
    de = 1'b1; hs = 1'b0; vs = 1'b0;
    @(posedge clk); #1;
    total++;
    assert ({vhs, vvs, r, g, b, ft} === {1'b1, 1'b1, 12'h000, 1'b0}) else begin
      bad++; $error("FAIL reset_state: got hs=%b vs=%b rgb=%h tick=%b want 1 1 000 0",
                    vhs, vvs, {r, g, b}, ft);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      px[i] = i * (HR / N); py[i] = i * (VR / N);
      xn[i] = 1'b0; yn[i] = (i % 2 == 1);
    end
    m_mode = 0; n_mode = 0; n_pause = 1'b0;
    q.delete();
    e.hs = 1'b1; e.vs = 1'b1; e.rgb = 12'h000;
    q.push_back(e);
  endtask

  task automatic frame();
    cyc(0, VR, 0, 1, 0);
    cyc(1, VR, 0, 1, 0);
    cyc(2, VR, 0, 1, 1);
    m_mode = n_mode;
    if (!n_pause)
      for (int i = 0; i < N; i++) begin
        mv(px[i], xn[i], HR, px[i], xn[i]);
        mv(py[i], yn[i], VR, py[i], yn[i]);
      end
  endtask

  initial begin
    rst = 1'b1; sx = '0; sy = '0; de = 1'b0; hs = 1'b1; vs = 1'b1; mode = '0; pause = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    // Pixels before the first tick use reset positions and mode 0.
    cyc(0, 0, 1, 1, 1);
    cyc(40, 30, 1, 0, 1);
    for (int f = 0; f < 300; f++) begin
      frame();
      for (int i = 0; i < N; i++) begin
        cyc(px[i], py[i], 1, 1'($urandom), 1'($urandom));
        cyc(px[i] + SZ - 1, py[i] + SZ - 1, 1, 1'($urandom), 1'($urandom));
        cyc(px[i] + SZ, py[i] + SZ - 1, 1, 1'($urandom), 1'($urandom));
        if (px[i] > 0) cyc(px[i] - 1, py[i], 1, 1'($urandom), 1'($urandom));
      end
      for (int k = 0; k < 6; k++)
        cyc($urandom_range(0, HR + 15), $urandom_range(0, VR - 1),
            $urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom));
      if (f == 150) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_sprite_compositor.md
# vga_sprite_compositor

Parametrised N-sprite bouncing-square compositor. It sits between `vga_sync` and the VGA pins and replaces the fixed two-square instance pair and combine logic in the top level. It tracks N squares that bounce off the screen edges, updating once per frame during vertical blanking. It composites them per pixel under a run-time-selectable overlap mode and drives registered, latency-matched sync and RGB outputs.

## Interface
Parameters:
- `N_SPR`, 4: number of sprites, 1–8.
- `SIZE`, 32: square edge length in pixels.
- `SPEED`, 1: pixels moved per frame on each axis.
- `H_RES`, 640: active width.
- `V_RES`, 480: active height.
- `CORDW`, 10: coordinate width.
- `BG_COLOR`, 12'h137: background RGB triplet.

Ports:
- `clk_pix` in 1: pixel clock (25.2 MHz).
- `rst_pix` in 1: synchronous reset, active-high.
- `sx` in CORDW: current pixel x from `vga_sync`.
- `sy` in CORDW: current pixel y from `vga_sync`.
- `de` in 1: data enable from `vga_sync`.
- `hsync` in 1: raw horizontal sync from `vga_sync`.
- `vsync` in 1: raw vertical sync from `vga_sync`.
- `mode` in 2: overlap mode request.
- `pause` in 1: freeze motion request.
- `vga_hsync` out 1: registered horizontal sync.
- `vga_vsync` out 1: registered vertical sync.
- `vga_r` out 4: registered red.
- `vga_g` out 4: registered green.
- `vga_b` out 4: registered blue.
- `frame_tick` out 1: one-cycle pulse marking each motion update.

## Operation
- Reset (`rst_pix`=1 at a clock edge):
  - Sprite i goes to x = i·(H_RES/N_SPR), y = i·(V_RES/N_SPR).
  - dx = +1 for all sprites; dy = +1 for even i, −1 for odd i.
  - Latched mode = 0, latched pause = 0.
  - All outputs = 0, except `vga_hsync` and `vga_vsync` = 1 (inactive, negative polarity).
- Frame tick:
  - Asserted for one cycle when (sx==0 && sy==V_RES), i.e. the first blanking line.
  - On that cycle `mode` and `pause` are latched. Neither changes mid-frame.
- Motion, on frame tick when latched pause = 0, per axis per sprite:
  - Moving +: if p+SPEED+SIZE > RES, then p ← RES−SIZE and the direction flips; otherwise p ← p+SPEED.
  - Moving −: if p < SPEED, then p ← 0 and the direction flips; otherwise p ← p−SPEED.
  - Both axes update independently in the same cycle. A corner hit flips both.
  - Positions are stable throughout the active area, so there is no tearing.
- Hit test: hit[i] = (x_i ≤ sx < x_i+SIZE) && (y_i ≤ sy < y_i+SIZE). Compare widths are CORDW+1, so there is no overflow.
- Sprite colour comes from package palette entry i (8 entries).
- Composite when no hit: BG_COLOR in every mode. When at least one hit:
  - Mode 0, priority: colour of the lowest-index hit sprite.
  - Mode 1, max: per-channel maximum over the hit sprites.
  - Mode 2, invert-overlap: one hit gives that sprite's colour; two or more give 12'h000.
  - Mode 3, additive: per-channel sum over the hit sprites, saturated at 4'hF.
- Blanking: when the delayed `de`=0, RGB = 0.

## Timing
- Stage 1 registers hit[N_SPR−1:0] together with de, hsync and vsync.
- Stage 2 registers the composite RGB and the syncs to the outputs.
- Latency is exactly 2 cycles from sx/sy/de/hsync/vsync to the pins, identical for sync and colour.
- `frame_tick` is registered. It is high during the cycle after (0, V_RES) is presented; positions hold their new values from the following cycle.
- If reset is asserted mid-frame, everything returns to reset values on the next edge. Output is valid 2 cycles after deassertion.
- A `pause` or `mode` change between ticks is ignored until the next tick.

## Structure
- Package `vga_pkg`:
  - CORDW, H_RES, V_RES.
  - Mode enum: MODE_PRIO, MODE_MAX, MODE_INV, MODE_ADD.
  - 8-entry 12-bit sprite palette.
  - Saturating 4-bit add function.
- Sub-module `vga_sprite_motion`:
  - One instance per sprite via generate.
  - Contains the position/direction registers, the bounce logic and the hit compare.
  - Parameters: start x/y and initial dy.

## Test plan
- N_SPR=2, reset, 1 tick -> sprite0 at (1,1), sprite1 at (321,239); `frame_tick` high exactly 1 cycle per frame.
- Sprite0 forced to x=608 moving +, tick -> x stays 608 and dx becomes −1; next tick -> 607. Sprite at y=0 moving − -> y stays 0 and flips to +.
- Sprites 0 and 1 both covering pixel (100,100), palette 12'hF00 and 12'hFFF -> mode0 F00, mode1 FFF, mode2 000, mode3 FFF. Mode changed mid-frame takes effect only after the next tick.
- pause=1 sampled at a tick -> positions unchanged for 3 frames; pause=0 -> motion resumes at the next tick.
- Check against sync input -> outputs exactly 2 cycles delayed. RGB = 0 whenever delayed de=0. Background pixel (0,0) with no hit -> 1/3/7.
- Reset asserted mid-line -> next edge gives RGB 0 and syncs 1; positions return to their start values.
